// File: rtl/centroid_accum_if.sv
// Bundle of the point-input, dump-output and status signals of
// centroid_accum_bank. The master drives points and dump requests and
// consumes output beats; the slave is the accumulator bank itself.
interface centroid_accum_if #(
   parameter int dim_num          = 7,
   parameter int cordinate_width  = 13,
   parameter int accum_cord_width = 22,
   parameter int idx_width        = 3,
   parameter int count_width      = 10
);
   logic                                  in_valid;
   logic                                  in_ready;
   logic [dim_num*cordinate_width-1:0]    point;
   logic [idx_width-1:0]                  centroid_idx;
   logic                                  dump_start;
   logic                                  out_valid;
   logic                                  out_ready;
   logic [idx_width-1:0]                  out_idx;
   logic [dim_num*accum_cord_width-1:0]   out_accum;
   logic [count_width-1:0]                out_count;
   logic                                  out_last;
   logic                                  idx_err;
   logic                                  cnt_ovf;
   logic                                  busy;

   modport master (
      output in_valid, point, centroid_idx, dump_start, out_ready,
      input  in_ready, out_valid, out_idx, out_accum, out_count, out_last,
             idx_err, cnt_ovf, busy
   );

   modport slave (
      input  in_valid, point, centroid_idx, dump_start, out_ready,
      output in_ready, out_valid, out_idx, out_accum, out_count, out_last,
             idx_err, cnt_ovf, busy
   );
endinterface

// File: rtl/centroid_accum_bank.sv
// Per-centroid coordinate-sum and point-count bank for one k-means
// iteration. Points are accumulated in ACCUM, streamed out one centroid
// per beat in DUMP, and the bank is wiped in a one-cycle CLEAR.
// Optional macro ACCUM_SAT_EN: coordinate sums saturate (and flag cnt_ovf)
// instead of wrapping modulo 2**accum_cord_width.
module centroid_accum_bank #(
   parameter int dim_num          = 7,
   parameter int cordinate_width  = 13,
   parameter int accum_cord_width = 22,
   parameter int centroid_num     = 8,
   parameter int idx_width        = 3,
   parameter int count_width      = 10
) (
   input logic               clk,
   input logic               rst,
   centroid_accum_if.slave   bus
);

   typedef enum logic [1:0] {ACCUM, DUMP, CLEAR} state_t;

   localparam logic [idx_width:0]   num_c    = (idx_width+1)'(centroid_num);
   localparam logic [idx_width-1:0] last_idx = idx_width'(centroid_num - 1);

   state_t                         state_q, state_d;
   logic [idx_width-1:0]           rd_ptr;
   logic [accum_cord_width-1:0]    acc_q [centroid_num][dim_num];
   logic [count_width-1:0]         cnt_q [centroid_num];
   logic [accum_cord_width-1:0]    sum_d [dim_num];
   logic [count_width-1:0]         cnt_next;
   logic                           cnt_full;
   logic                           add_sat;
   logic                           accept;
   logic                           idx_ok;
   logic [idx_width-1:0]           idx_safe;
   logic                           beat_done;
   logic                           idx_err_q, cnt_ovf_q;
`ifdef ACCUM_SAT_EN
   logic [accum_cord_width:0]      ext_sum [dim_num];
`endif

   assign accept    = bus.in_valid && bus.in_ready;
   assign idx_ok    = {1'b0, bus.centroid_idx} < num_c;
   assign idx_safe  = idx_ok ? bus.centroid_idx : '0;
   assign beat_done = bus.out_valid && bus.out_ready;

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ACCUM;
      else     state_q <= state_d;
   end

   // Next-state and handshake outputs.
   // NOTE: every output gets a default before the case so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b1;
      case (state_q)
         ACCUM: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b0;
            if (bus.dump_start) state_d = DUMP;
         end
         DUMP: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready && rd_ptr == last_idx) state_d = CLEAR;
         end
         CLEAR:   state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   // Read pointer: parked at 0 outside DUMP, advances on each accepted beat.
   always_ff @(posedge clk) begin
      if (rst || state_q != DUMP) rd_ptr <= '0;
      else if (beat_done)         rd_ptr <= (rd_ptr == last_idx) ? '0 : rd_ptr + 1'b1;
   end

   // Per-coordinate sum of the addressed centroid and the incoming point.
   always_comb begin
      add_sat = 1'b0;
      for (int d = 0; d < dim_num; d++) begin
`ifdef ACCUM_SAT_EN
         ext_sum[d] = {1'b0, acc_q[idx_safe][d]}
                    + (accum_cord_width+1)'(bus.point[d*cordinate_width +: cordinate_width]);
         if (ext_sum[d][accum_cord_width]) begin
            sum_d[d] = '1;
            add_sat  = 1'b1;
         end else begin
            sum_d[d] = ext_sum[d][accum_cord_width-1:0];
         end
`else
         sum_d[d] = acc_q[idx_safe][d]
                  + accum_cord_width'(bus.point[d*cordinate_width +: cordinate_width]);
`endif
      end
   end

   // Saturating point counter of the addressed centroid.
   assign cnt_full = (cnt_q[idx_safe] == '1);
   assign cnt_next = cnt_full ? cnt_q[idx_safe] : cnt_q[idx_safe] + 1'b1;

   // Accumulator/counter bank: cleared by reset or CLEAR, updated on accept.
   // NOTE: this storage is reset on purpose -- every epoch must start from
   // zero, so it is built from resettable flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (rst || state_q == CLEAR) begin
         for (int c = 0; c < centroid_num; c++) begin
            cnt_q[c] <= '0;
            for (int d = 0; d < dim_num; d++) acc_q[c][d] <= '0;
         end
      end else if (accept && idx_ok) begin
         cnt_q[idx_safe] <= cnt_next;
         for (int d = 0; d < dim_num; d++) acc_q[idx_safe][d] <= sum_d[d];
      end
   end

   // Sticky error flags for the current epoch.
   always_ff @(posedge clk) begin
      if (rst || state_q == CLEAR) begin
         idx_err_q <= 1'b0;
         cnt_ovf_q <= 1'b0;
      end else if (accept) begin
         if (!idx_ok)                  idx_err_q <= 1'b1;
         else if (cnt_full || add_sat) cnt_ovf_q <= 1'b1;
      end
   end

   // Dump beat: registers of the centroid under the read pointer.
   always_comb begin
      bus.out_accum = '0;
      for (int d = 0; d < dim_num; d++)
         bus.out_accum[d*accum_cord_width +: accum_cord_width] = acc_q[rd_ptr][d];
   end

   assign bus.out_idx   = rd_ptr;
   assign bus.out_count = cnt_q[rd_ptr];
   assign bus.out_last  = bus.out_valid && (rd_ptr == last_idx);
   assign bus.idx_err   = idx_err_q;
   assign bus.cnt_ovf   = cnt_ovf_q;

endmodule

// File: tb/tb_centroid_accum_bank.sv
// Directed bench for centroid_accum_bank: a default 8-centroid instance
// and a 6-centroid / 18-bit-sum instance for the index and width corners.
module tb_centroid_accum_bank;

   localparam int DIM  = 7;
   localparam int CW   = 13;
   localparam int ACW  = 22;
   localparam int CN   = 8;
   localparam int IW   = 3;
   localparam int CNTW = 10;
   localparam int ACW6 = 18;
   localparam int CN6  = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   centroid_accum_if #(.dim_num(DIM), .cordinate_width(CW), .accum_cord_width(ACW),
                       .idx_width(IW), .count_width(CNTW)) bus ();
   centroid_accum_if #(.dim_num(DIM), .cordinate_width(CW), .accum_cord_width(ACW6),
                       .idx_width(IW), .count_width(CNTW)) bus6 ();

   centroid_accum_bank #(.dim_num(DIM), .cordinate_width(CW), .accum_cord_width(ACW),
                         .centroid_num(CN), .idx_width(IW), .count_width(CNTW))
      u_dut (.clk(clk), .rst(rst), .bus(bus));

   centroid_accum_bank #(.dim_num(DIM), .cordinate_width(CW), .accum_cord_width(ACW6),
                         .centroid_num(CN6), .idx_width(IW), .count_width(CNTW))
      u_dut6 (.clk(clk), .rst(rst), .bus(bus6));

   typedef struct {
      int idx;
      int val;
   } pt_vec_t;

   int      checks = 0;
   int      errors = 0;
   int      exp_sum [CN];
   int      exp_cnt [CN];
   pt_vec_t vecs [7];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [DIM*CW-1:0] mk_pt(input int v);
      logic [DIM*CW-1:0] r;
      r = '0;
      for (int d = 0; d < DIM; d++) r[d*CW +: CW] = CW'(v);
      return r;
   endfunction

   // Every coordinate equal to v, in a w-bit field each.
   function automatic logic [255:0] rep(input longint v, input int w);
      logic [255:0] r, one, fld;
      r   = '0;
      one = 256'd1;
      fld = 256'(v) & ((one << w) - one);
      for (int d = 0; d < DIM; d++) r = r | (fld << (d*w));
      return r;
   endfunction

   task automatic clear_model();
      for (int b = 0; b < CN; b++) begin
         exp_sum[b] = 0;
         exp_cnt[b] = 0;
      end
   endtask

   // Full dump of the default instance, checked against the model.
   // stall: out_ready follows 1,0,0,1 repeating; pt_same: a point to idx 0
   // rides the dump_start cycle; junk: in_valid held high during DUMP.
   task automatic dump_main(input string tag, input bit stall, input bit pt_same, input bit junk);
      int                  beat;
      int                  cyc;
      bit                  held;
      bit                  rdy;
      logic [IW-1:0]       h_idx;
      logic [DIM*ACW-1:0]  h_acc;
      logic [CNTW-1:0]     h_cnt;
      beat = 0;
      cyc  = 0;
      held = 1'b0;
      h_idx = '0;
      h_acc = '0;
      h_cnt = '0;
      @(negedge clk);
      bus.dump_start = 1'b1;
      if (pt_same) begin
         bus.in_valid     = 1'b1;
         bus.centroid_idx = '0;
         bus.point        = mk_pt(1);
         exp_sum[0]      += 1;
         exp_cnt[0]      += 1;
      end
      @(negedge clk);
      bus.dump_start   = 1'b0;
      bus.in_valid     = junk;
      bus.centroid_idx = 3'd4;
      bus.point        = mk_pt(9);
      while (beat < CN && cyc < 64) begin
         rdy = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         bus.out_ready = rdy;
         check($sformatf("%s_out_valid_c%0d", tag, cyc), bus.out_valid, 1);
         check($sformatf("%s_in_ready_c%0d", tag, cyc), bus.in_ready, 0);
         check($sformatf("%s_busy_c%0d", tag, cyc), bus.busy, 1);
         if (held) begin
            check($sformatf("%s_hold_idx_c%0d", tag, cyc), bus.out_idx, h_idx);
            check($sformatf("%s_hold_acc_c%0d", tag, cyc), bus.out_accum, h_acc);
            check($sformatf("%s_hold_cnt_c%0d", tag, cyc), bus.out_count, h_cnt);
         end
         if (rdy) begin
            check($sformatf("%s_idx_b%0d", tag, beat), bus.out_idx, beat);
            check($sformatf("%s_acc_b%0d", tag, beat), bus.out_accum, rep(exp_sum[beat], ACW));
            check($sformatf("%s_cnt_b%0d", tag, beat), bus.out_count, exp_cnt[beat]);
            check($sformatf("%s_last_b%0d", tag, beat), bus.out_last, beat == CN-1);
            beat++;
            held = 1'b0;
         end else begin
            held  = 1'b1;
            h_idx = bus.out_idx;
            h_acc = bus.out_accum;
            h_cnt = bus.out_count;
         end
         cyc++;
         @(negedge clk);
      end
      if (beat < CN) check({tag, "_beat_timeout"}, beat, CN);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      check({tag, "_clear_out_valid"}, bus.out_valid, 0);
      check({tag, "_clear_in_ready"}, bus.in_ready, 0);
      check({tag, "_clear_busy"}, bus.busy, 1);
      clear_model();
      @(negedge clk);
      check({tag, "_accum_busy"}, bus.busy, 0);
      check({tag, "_accum_in_ready"}, bus.in_ready, 1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint exp_b1;

      vecs[0] = '{2, 100};
      vecs[1] = '{2, 200};
      vecs[2] = '{2, 300};
      vecs[3] = '{5, 8191};
      vecs[4] = '{5, 8191};
      vecs[5] = '{5, 8191};
      vecs[6] = '{5, 8191};

      bus.in_valid = 1'b0;  bus.point = '0;  bus.centroid_idx = '0;
      bus.dump_start = 1'b0; bus.out_ready = 1'b0;
      bus6.in_valid = 1'b0; bus6.point = '0; bus6.centroid_idx = '0;
      bus6.dump_start = 1'b0; bus6.out_ready = 1'b0;
      clear_model();

      // Reset state.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_idx_err", bus.idx_err, 0);
      check("rst_cnt_ovf", bus.cnt_ovf, 0);
      check("rst_out_idx", bus.out_idx, 0);
      rst = 1'b0;

      // Point stream from the vector table, back-to-back.
      foreach (vecs[i]) begin
         @(negedge clk);
         check($sformatf("stream_in_ready_%0d", i), bus.in_ready, 1);
         bus.in_valid     = 1'b1;
         bus.centroid_idx = IW'(vecs[i].idx);
         bus.point        = mk_pt(vecs[i].val);
         exp_sum[vecs[i].idx] += vecs[i].val;
         exp_cnt[vecs[i].idx] += 1;
      end
      @(negedge clk);
      check("stream_in_ready_end", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      dump_main("dumpA", 1'b0, 1'b0, 1'b0);

      // Second dump right after CLEAR reads all zeros.
      dump_main("dumpB", 1'b0, 1'b0, 1'b0);

      // Point on the dump_start cycle, in_valid held during DUMP, stalled out_ready.
      dump_main("dumpC", 1'b1, 1'b1, 1'b1);

      // Reset in the middle of a dump.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.centroid_idx = 3'd6; bus.point = mk_pt(50);
      @(negedge clk);
      bus.in_valid = 1'b0; bus.dump_start = 1'b1;
      @(negedge clk);
      bus.dump_start = 1'b0; bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_dump_at_beat3", bus.out_idx, 3);
      rst = 1'b1; bus.out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("rstdump_out_valid", bus.out_valid, 0);
      check("rstdump_busy", bus.busy, 0);
      check("rstdump_in_ready", bus.in_ready, 1);
      check("rstdump_out_idx", bus.out_idx, 0);
      clear_model();
      dump_main("dumpD", 1'b0, 1'b0, 1'b0);

      // Six-centroid instance: bad index, counter and sum-width corners.
      @(negedge clk);
      bus6.in_valid = 1'b1; bus6.centroid_idx = 3'd7; bus6.point = mk_pt(5);
      @(negedge clk);
      bus6.in_valid = 1'b0;
      check("b6_idx_err", bus6.idx_err, 1);
      check("b6_cnt_ovf_clean", bus6.cnt_ovf, 0);
      check("b6_in_ready", bus6.in_ready, 1);
      for (int i = 0; i < 1024; i++) begin
         bus6.in_valid = 1'b1; bus6.centroid_idx = 3'd0; bus6.point = mk_pt(1);
         @(negedge clk);
      end
      for (int i = 0; i < 64; i++) begin
         bus6.in_valid = 1'b1; bus6.centroid_idx = 3'd1; bus6.point = mk_pt(8191);
         @(negedge clk);
      end
      bus6.in_valid = 1'b0;
      check("b6_cnt_ovf", bus6.cnt_ovf, 1);

`ifdef ACCUM_SAT_EN
      exp_b1 = (64'd1 << ACW6) - 1;
`else
      exp_b1 = (64 * 8191) % (64'd1 << ACW6);
`endif
      bus6.dump_start = 1'b1;
      @(negedge clk);
      bus6.dump_start = 1'b0; bus6.out_ready = 1'b1;
      for (int b = 0; b < CN6; b++) begin
         check($sformatf("b6_valid_b%0d", b), bus6.out_valid, 1);
         check($sformatf("b6_idx_b%0d", b), bus6.out_idx, b);
         check($sformatf("b6_last_b%0d", b), bus6.out_last, b == CN6-1);
         check($sformatf("b6_acc_b%0d", b), bus6.out_accum,
               rep((b == 0) ? 1024 : (b == 1) ? exp_b1 : 0, ACW6));
         check($sformatf("b6_cnt_b%0d", b), bus6.out_count,
               (b == 0) ? 1023 : (b == 1) ? 64 : 0);
         if (b == 0) begin
            check("b6_dump_idx_err", bus6.idx_err, 1);
            check("b6_dump_cnt_ovf", bus6.cnt_ovf, 1);
         end
         @(negedge clk);
      end
      bus6.out_ready = 1'b0;
      check("b6_clear_out_valid", bus6.out_valid, 0);
      @(negedge clk);
      check("b6_post_idx_err", bus6.idx_err, 0);
      check("b6_post_cnt_ovf", bus6.cnt_ovf, 0);
      check("b6_post_busy", bus6.busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
